// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX display arbiter: segment type,
// active-low segment table, blank pattern and arbiter state encoding.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Active-low gfedcba encodings for nibbles 0..F.
  localparam seg_t SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_OFF : SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter with minimum dwell sharing six HEX displays between requesters.
// Optional HEX_LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DIGITS       = 6,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*4*DIGITS-1:0] value,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [DIGITS*7-1:0]         hex_out
);

  localparam int VW = 4 * DIGITS;
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [CW-1:0]      CNT_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0]      LAST_RST = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t          state;
  logic [PW-1:0]   last;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   snap;
  logic            found;
  logic [PW-1:0]   pick;
  int              idx;
  logic [VW-1:0]   val_arr [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_val
    assign val_arr[r] = value[r*VW +: VW];
  end

  // Search from last+1 with wrap; in HOLD the owner (always == last) is skipped,
  // which is the offset that lands back on last.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[PW-1:0]] && !(state == HOLD && off == NUM_REQ)) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      case (state)
        IDLE: begin
          if (found) begin
            state <= HOLD;
            grant <= ONE_HOT0 << pick;
            last  <= pick;
            cnt   <= CNT_LOAD;
            snap  <= val_arr[pick];
          end
        end
        HOLD: begin
          if (!req[last] || cnt == '0) begin
            if (found) begin
              grant <= ONE_HOT0 << pick;
              last  <= pick;
              cnt   <= CNT_LOAD;
              snap  <= val_arr[pick];
            end else if (!req[last]) begin
              state <= IDLE;
              grant <= '0;
            end else begin
              cnt   <= CNT_LOAD;
              snap  <= val_arr[last];
            end
          end else begin
            cnt  <= cnt - 1'b1;
            snap <= val_arr[last];
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign busy = |grant;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic blank;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    if (d == 0) begin : g_lsd
      assign blank = (state == IDLE);
    end else begin : g_upper
      assign blank = (state == IDLE) || (snap[VW-1:4*d] == '0);
    end
`else
    assign blank = (state == IDLE);
`endif
    hex_seg_decode u_dec (
      .nibble (snap[4*d +: 4]),
      .blank  (blank),
      .seg    (hex_out[7*d +: 7])
    );
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter with DWELL_CYCLES=4 and two requesters;
// a cycle-level model plus hand-computed literal checks.
module tb_hex_display_arbiter;

  localparam int NREQ  = 2;
  localparam int DIG   = 6;
  localparam int DWELL = 4;

  localparam logic [6:0]  OFF     = 7'b1111111;
  localparam logic [41:0] ALL_OFF = {6{OFF}};

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [47:0]   value;
  logic [1:0]    grant;
  logic          busy;
  logic [41:0]   hex_out;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  hex_display_arbiter #(
    .NUM_REQ      (NREQ),
    .DIGITS       (DIG),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .value   (value),
    .grant   (grant),
    .busy    (busy),
    .hex_out (hex_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_val(input int k, input logic [23:0] v);
    value[24*k +: 24] = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Model: owner (-1 = none), cycles the current grant has been held, pointer, snapshot.
  int          owner  = -1;
  int          m_last = NREQ - 1;
  int          held   = 0;
  int          nxt    = -1;
  logic [23:0] msnap  = '0;

  function automatic int m_pick(input int from, input int excl);
    for (int off = 1; off <= NREQ; off++) begin
      int k;
      k = (from + off) % NREQ;
      if (req[k] && k != excl) return k;
    end
    return -1;
  endfunction

  function automatic logic [41:0] model_hex();
    logic [41:0] h;
    h = ALL_OFF;
    if (owner >= 0) begin
      for (int d = 0; d < DIG; d++) begin
        h[7*d +: 7] = seg_tab[msnap[4*d +: 4]];
`ifdef HEX_LEADING_ZERO_BLANK_EN
        if (d > 0 && (msnap >> (4*d)) == 0) h[7*d +: 7] = OFF;
`endif
      end
    end
    return h;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  = -1;
      m_last = NREQ - 1;
      held   = 0;
      msnap  = '0;
    end else begin
      if (owner < 0) nxt = m_pick(m_last, -1);
      else if (!req[owner]) nxt = m_pick(m_last, owner);
      else if (held >= DWELL) begin
        nxt = m_pick(m_last, owner);
        if (nxt < 0) nxt = owner;
      end else nxt = owner;
      if (nxt >= 0) begin
        if (nxt != owner || held >= DWELL) held = 1;
        else held++;
        msnap  = value[24*nxt +: 24];
        m_last = nxt;
      end
      owner = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_grant", 64'(grant), (owner >= 0) ? 64'(1 << owner) : 64'd0);
      check("model_busy", 64'(busy), 64'(owner >= 0));
      check("model_hex", 64'(hex_out), 64'(model_hex()));
    end
  end

  logic [1:0] mix_req [16] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                               2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};

  initial begin
    req   = '0;
    value = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (5) begin
      @(negedge clk);
      check("idle_grant", 64'(grant), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_hex", 64'(hex_out), 64'(ALL_OFF));
    end

    // Single requester, full hex decode.
    req = 2'b01;
    set_val(0, 24'h12AB3F);
    @(negedge clk);
    check("single_grant", 64'(grant), 64'd1);
    check("single_hex", 64'(hex_out),
          64'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011, 7'b0110000, 7'b0001110}));
    repeat (6) @(negedge clk);
    check("single_keep", 64'(grant), 64'd1);

    set_val(0, 24'h00000A);
    @(negedge clk);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    check("live_hex_a", 64'(hex_out), 64'({{5{OFF}}, 7'b0001000}));
`else
    check("live_hex_a", 64'(hex_out), 64'({{5{7'b1000000}}, 7'b0001000}));
`endif
    set_val(0, 24'h000000);
    @(negedge clk);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    check("live_hex_0", 64'(hex_out), 64'({{5{OFF}}, 7'b1000000}));
`else
    check("live_hex_0", 64'(hex_out), 64'({6{7'b1000000}}));
`endif
    req = 2'b00;
    @(negedge clk);
    check("release_grant", 64'(grant), 64'd0);
    check("release_hex", 64'(hex_out), 64'(ALL_OFF));

    // Round-robin with dwell of 4.
    do_reset();
    set_val(0, 24'h000005);
    set_val(1, 24'hC0FFEE);
    req = 2'b11;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("rr_grant", 64'(grant), (c < 4) ? 64'd1 : ((c < 8) ? 64'd2 : 64'd1));
      if (c == 4)
        check("rr_hex", 64'(hex_out),
              64'({7'b1000110, 7'b1000000, 7'b0001110, 7'b0001110, 7'b0000110, 7'b0000110}));
    end

    // Early release to another requester, then to idle.
    do_reset();
    req = 2'b11;
    repeat (2) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    check("early_to_1", 64'(grant), 64'd2);
    req = 2'b00;
    @(negedge clk);
    check("early_idle_grant", 64'(grant), 64'd0);
    check("early_idle_hex", 64'(hex_out), 64'(ALL_OFF));
    req = 2'b01;
    @(negedge clk);
    check("early_g0", 64'(grant), 64'd1);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    check("early_g0_drop", 64'(grant), 64'd0);
    check("early_g0_busy", 64'(busy), 64'd0);
    check("early_g0_hex", 64'(hex_out), 64'(ALL_OFF));

    // Reset mid-HOLD: pointer was left at 0, so requester 1 wins before reset.
    req = 2'b11;
    repeat (2) @(negedge clk);
    check("pre_reset_grant", 64'(grant), 64'd2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_grant", 64'(grant), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_hex", 64'(hex_out), 64'(ALL_OFF));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_grant", 64'(grant), 64'd1);

    // Mixed directed vectors, checked by the model every cycle.
    for (int i = 0; i < 16; i++) begin
      req = mix_req[i];
      set_val(0, 24'(32'h000100 * i + i));
      set_val(1, 24'(32'hABC000 + i));
      @(negedge clk);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
